// File: rtl/cla_seq_add_ctrl.sv
// Sequences one shared CHUNK_W-bit carry-lookahead adder over N_CHUNKS chunks,
// LSB first, chaining each chunk's carry-out into the next chunk's carry-in.
module cla_seq_add_ctrl #(
    parameter int CHUNK_W  = 16,
    parameter int N_CHUNKS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [CHUNK_W*N_CHUNKS-1:0]   in_a,
    input  logic [CHUNK_W*N_CHUNKS-1:0]   in_b,
    input  logic                          cin,
    output logic                          busy,
    output logic                          done,
    output logic [CHUNK_W*N_CHUNKS-1:0]   sum,
    output logic                          cout,
    output logic                          overflow,
    output logic [CHUNK_W-1:0]            cla_a,
    output logic [CHUNK_W-1:0]            cla_b,
    output logic                          cla_cin,
    input  logic [CHUNK_W-1:0]            cla_sum,
    input  logic                          cla_cout
);

    localparam int W     = CHUNK_W * N_CHUNKS;
    localparam int IDX_W = $clog2(N_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic [W-1:0]      work_sum;
    logic              carry_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            work_sum  <= '0;
            carry_reg <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        carry_reg <= cin;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    work_sum[idx*CHUNK_W +: CHUNK_W] <= cla_sum;
                    carry_reg                        <= cla_cout;
                    // The top chunk goes straight to the outputs, so sum never shows a partial value.
                    if (idx == LAST_IDX) begin
                        sum      <= {cla_sum, work_sum[W-CHUNK_W-1:0]};
                        cout     <= cla_cout;
                        overflow <= (a_reg[W-1] == b_reg[W-1]) &&
                                    (cla_sum[CHUNK_W-1] != a_reg[W-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        cla_a      = '0;
        cla_b      = '0;
        cla_cin    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                cla_a   = a_reg[idx*CHUNK_W +: CHUNK_W];
                cla_b   = b_reg[idx*CHUNK_W +: CHUNK_W];
                cla_cin = carry_reg;
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
